// File: rtl/band_loader.sv
// band_loader: streams raster pixels into FILTER_SIZE circular line banks and
// presents each vertical band top-row-first under a valid/ready handshake.
// Optional feature: define ZERO_PAD_EN to insert (FILTER_SIZE-1)/2 all-zero
// rows above and below the frame.
module band_loader #(
  parameter int IMAGE_WIDTH  = 5,
  parameter int IMAGE_HEIGHT = 5,
  parameter int FILTER_SIZE  = 3,
  parameter int PIXEL_W      = 8,
  parameter int ROW_STRIDE   = 1
) (
  input  logic                                      clk,
  input  logic                                      rst,
  input  logic                                      pix_valid,
  output logic                                      pix_ready,
  input  logic [PIXEL_W-1:0]                        pix_data,
  output logic                                      band_valid,
  input  logic                                      band_ready,
  output logic [FILTER_SIZE*IMAGE_WIDTH*PIXEL_W-1:0] row_buffer_flat,
  output logic [$clog2(IMAGE_HEIGHT+FILTER_SIZE):0] band_row,
  output logic                                      frame_done
);

  localparam int BRW = $clog2(IMAGE_HEIGHT+FILTER_SIZE) + 1;
`ifdef ZERO_PAD_EN
  localparam int PAD = (FILTER_SIZE-1)/2;
`else
  localparam int PAD = 0;
`endif
  localparam int H_EFF     = IMAGE_HEIGHT + 2*PAD;
  localparam int NUM_BANDS = (H_EFF - FILTER_SIZE)/ROW_STRIDE + 1;
  localparam int CW        = $clog2(IMAGE_WIDTH+1);
  localparam int WPW       = $clog2(FILTER_SIZE+1);
  localparam int IRW       = $clog2(IMAGE_HEIGHT+1);

  typedef enum logic [2:0] {IDLE, PAD_TOP, FILL, PRESENT, SKIP, PAD_BOT} state_t;

  state_t             state, state_d;
  logic [CW-1:0]      col;
  logic [WPW-1:0]     wp;
  logic [IRW-1:0]     in_row;
  logic [WPW-1:0]     rows_need;
  logic [BRW-1:0]     band_cnt;
  logic [BRW-1:0]     band_row_r;
  logic               frame_done_r;
  logic [PIXEL_W-1:0] bank [FILTER_SIZE][IMAGE_WIDTH];

  logic accept;
  logic row_end;
  logic last_band;
  logic rows_exhausted;

  assign accept         = pix_valid && pix_ready;
  assign row_end        = accept && (col == CW'(IMAGE_WIDTH-1));
  assign last_band      = (band_cnt == BRW'(NUM_BANDS-1));
  assign rows_exhausted = (in_row == IRW'(IMAGE_HEIGHT));
  assign band_row       = band_row_r;
  assign frame_done     = frame_done_r;

  function automatic logic [WPW-1:0] wp_inc(input logic [WPW-1:0] p);
    return (p == WPW'(FILTER_SIZE-1)) ? '0 : p + WPW'(1);
  endfunction

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_d;
  end

  // Next-state and handshake decode from registered state
  always_comb begin
    state_d    = state;
    pix_ready  = 1'b0;
    band_valid = 1'b0;
    case (state)
      IDLE: begin
`ifdef ZERO_PAD_EN
        state_d = (PAD > 0) ? PAD_TOP : FILL;
`else
        state_d = FILL;
`endif
      end
      PAD_TOP: begin
        if (rows_need == WPW'(1)) state_d = FILL;
      end
      FILL: begin
        pix_ready = 1'b1;
        if (row_end) begin
          if (rows_need == WPW'(1)) state_d = PRESENT;
`ifdef ZERO_PAD_EN
          else if (in_row == IRW'(IMAGE_HEIGHT-1)) state_d = PAD_BOT;
`endif
        end
      end
      PRESENT: begin
        band_valid = 1'b1;
        if (band_ready) begin
          if (last_band) state_d = SKIP;
`ifdef ZERO_PAD_EN
          else if (rows_exhausted) state_d = PAD_BOT;
`endif
          else state_d = FILL;
        end
      end
      SKIP: begin
        pix_ready = !rows_exhausted;
        if (rows_exhausted) state_d = IDLE;
      end
      PAD_BOT: begin
        if (rows_need == WPW'(1)) state_d = PRESENT;
      end
      default: state_d = IDLE;
    endcase
  end

  // Counters, pointers and line-bank writes
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      col          <= '0;
      wp           <= '0;
      in_row       <= '0;
      rows_need    <= '0;
      band_cnt     <= '0;
      band_row_r   <= '0;
      frame_done_r <= 1'b0;
      for (int unsigned i = 0; i < FILTER_SIZE; i++)
        for (int unsigned j = 0; j < IMAGE_WIDTH; j++)
          bank[WPW'(i)][CW'(j)] <= '0;
    end else begin
      frame_done_r <= (state == SKIP) && rows_exhausted;
      case (state)
        IDLE: begin
          col        <= '0;
          wp         <= '0;
          in_row     <= '0;
          band_cnt   <= '0;
          band_row_r <= '0;
          rows_need  <= (PAD > 0) ? WPW'(PAD) : WPW'(FILTER_SIZE);
        end
        PAD_TOP: begin
          for (int unsigned j = 0; j < IMAGE_WIDTH; j++) bank[wp][CW'(j)] <= '0;
          wp        <= wp_inc(wp);
          // the last top pad row hands over to FILL with the image rows still owed
          rows_need <= (rows_need == WPW'(1)) ? WPW'(FILTER_SIZE-PAD) : rows_need - WPW'(1);
        end
        FILL: begin
          if (accept) begin
            bank[wp][col] <= pix_data;
            if (row_end) begin
              col       <= '0;
              wp        <= wp_inc(wp);
              in_row    <= in_row + IRW'(1);
              rows_need <= rows_need - WPW'(1);
            end else begin
              col <= col + CW'(1);
            end
          end
        end
        PRESENT: begin
          if (band_ready) begin
            band_cnt   <= band_cnt + BRW'(1);
            band_row_r <= band_row_r + BRW'(ROW_STRIDE);
            rows_need  <= WPW'(ROW_STRIDE);
          end
        end
        SKIP: begin
          if (accept) begin
            if (row_end) begin
              col    <= '0;
              in_row <= in_row + IRW'(1);
            end else begin
              col <= col + CW'(1);
            end
          end
        end
        PAD_BOT: begin
          for (int unsigned j = 0; j < IMAGE_WIDTH; j++) bank[wp][CW'(j)] <= '0;
          wp        <= wp_inc(wp);
          rows_need <= rows_need - WPW'(1);
        end
        default: ;
      endcase
    end
  end

  // Slot i reads bank (wp+i) mod FILTER_SIZE so the oldest row comes first
  always_comb begin
    row_buffer_flat = '0;
    for (int unsigned i = 0; i < FILTER_SIZE; i++) begin : slot
      int unsigned    idx;
      logic [WPW-1:0] sel_b;
      idx = int'(wp) + i;
      if (idx >= FILTER_SIZE) idx = idx - FILTER_SIZE;
      sel_b = WPW'(idx);
      for (int unsigned j = 0; j < IMAGE_WIDTH; j++)
        row_buffer_flat[(i*IMAGE_WIDTH+j)*PIXEL_W +: PIXEL_W] = bank[sel_b][CW'(j)];
    end
  end

endmodule

// File: tb/tb_band_loader.sv
// Directed bench for band_loader: three parameterisations share clk/rst and
// a selected stream; expected bands are built from the row*16+col pattern.
module tb_band_loader;
  localparam int W    = 5;
  localparam int F    = 3;
  localparam int PW   = 8;
  localparam int FLAT = F*W*PW;
`ifdef ZERO_PAD_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic rst;
  int   sel;
  logic pv_s, br_s;
  logic [PW-1:0] pd_s;

  logic pv0, pv1, pv2, br0, br1, br2;
  logic pr0, pr1, pr2, bv0, bv1, bv2, fd0, fd1, fd2;
  logic [FLAT-1:0] rb0, rb1, rb2;
  logic [3:0] brow0, brow1;
  logic [4:0] brow2;

  assign pv0 = pv_s && (sel == 0);
  assign pv1 = pv_s && (sel == 1);
  assign pv2 = pv_s && (sel == 2);
  assign br0 = br_s && (sel == 0);
  assign br1 = br_s && (sel == 1);
  assign br2 = br_s && (sel == 2);

  band_loader #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(5), .FILTER_SIZE(F), .PIXEL_W(PW), .ROW_STRIDE(1)) u0 (
    .clk(clk), .rst(rst), .pix_valid(pv0), .pix_ready(pr0), .pix_data(pd_s),
    .band_valid(bv0), .band_ready(br0), .row_buffer_flat(rb0), .band_row(brow0), .frame_done(fd0));
  band_loader #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(5), .FILTER_SIZE(F), .PIXEL_W(PW), .ROW_STRIDE(2)) u1 (
    .clk(clk), .rst(rst), .pix_valid(pv1), .pix_ready(pr1), .pix_data(pd_s),
    .band_valid(bv1), .band_ready(br1), .row_buffer_flat(rb1), .band_row(brow1), .frame_done(fd1));
  band_loader #(.IMAGE_WIDTH(W), .IMAGE_HEIGHT(6), .FILTER_SIZE(F), .PIXEL_W(PW), .ROW_STRIDE(2)) u2 (
    .clk(clk), .rst(rst), .pix_valid(pv2), .pix_ready(pr2), .pix_data(pd_s),
    .band_valid(bv2), .band_ready(br2), .row_buffer_flat(rb2), .band_row(brow2), .frame_done(fd2));

  logic s_pr, s_bv, s_fd;
  logic [FLAT-1:0] s_rb;
  logic [4:0] s_brow;

  always_comb begin
    s_pr = pr0; s_bv = bv0; s_fd = fd0; s_rb = rb0; s_brow = {1'b0, brow0};
    case (sel)
      1: begin s_pr = pr1; s_bv = bv1; s_fd = fd1; s_rb = rb1; s_brow = {1'b0, brow1}; end
      2: begin s_pr = pr2; s_bv = bv2; s_fd = fd2; s_rb = rb2; s_brow = brow2; end
      default: ;
    endcase
  end

  int tests = 0;
  int fails = 0;

  task automatic chk(input string tag, input logic [FLAT-1:0] obs, input logic [FLAT-1:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Band k, slot i holds image row k*S+i-P, or zeros outside the image
  function automatic logic [FLAT-1:0] exp_band(input int k, input int s, input int h);
    logic [FLAT-1:0] e;
    int r;
    logic [7:0] v;
    e = '0;
    for (int i = 0; i < F; i++) begin
      r = k*s + i - P;
      for (int j = 0; j < W; j++) begin
        v = (r < 0 || r >= h) ? 8'h00 : 8'(r*16 + j);
        e[(i*W+j)*PW +: PW] = v;
      end
    end
    return e;
  endfunction

  task automatic check_reset(input string tag);
    chk({tag, "_pix_ready"}, FLAT'(s_pr), '0);
    chk({tag, "_band_valid"}, FLAT'(s_bv), '0);
    chk({tag, "_row_buffer"}, s_rb, '0);
    chk({tag, "_band_row"}, FLAT'(s_brow), '0);
    chk({tag, "_frame_done"}, FLAT'(s_fd), '0);
  endtask

  task automatic run_frame(input int d, input int h, input int s, input bit stall, input bit abort);
    int  pidx, bcnt, fdcnt, stallc, cyc, post, nb;
    bit  hs_prev, done;
    nb = (h + 2*P - F)/s + 1;
    pidx = 0; bcnt = 0; fdcnt = 0; stallc = 0; cyc = 0; post = 0;
    hs_prev = 1'b0; done = 1'b0;
    sel = d; pv_s = 1'b0; br_s = 1'b1;
    while (!done && cyc < 400) begin
      @(negedge clk);
      cyc++;
      if (hs_prev) begin
        chk("bubble_band_valid", FLAT'(s_bv), '0);
        if (bcnt < nb && pidx < h*W) chk("pix_ready_after_hs", FLAT'(s_pr), FLAT'(1));
      end
      hs_prev = 1'b0;
      if (s_bv) begin
        chk($sformatf("band%0d_data", bcnt), s_rb, exp_band(bcnt, s, h));
        chk($sformatf("band%0d_row", bcnt), FLAT'(s_brow), FLAT'(bcnt*s));
        if (stall && bcnt == 1 && stallc < 10) begin
          chk("stall_pix_ready", FLAT'(s_pr), '0);
          stallc++;
          br_s = 1'b0;
        end else begin
          br_s = 1'b1;
          bcnt++;
          hs_prev = 1'b1;
        end
      end
      if (s_fd) begin
        fdcnt++;
        chk("done_after_last_band", FLAT'(bcnt), FLAT'(nb));
      end
      pv_s = (pidx < h*W);
      pd_s = 8'((pidx / W)*16 + (pidx % W));
      if (s_pr && pv_s) pidx++;
      if (fdcnt > 0) post++;
      if (post >= 5) done = 1'b1;
      if (abort && bcnt >= 1 && pidx >= (F-P)*W + 2) done = 1'b1;
    end
    if (!abort) begin
      pv_s = 1'b0;
      chk("frame_timeout", FLAT'(cyc < 400), FLAT'(1));
      chk("band_count", FLAT'(bcnt), FLAT'(nb));
      chk("frame_done_pulses", FLAT'(fdcnt), FLAT'(1));
      chk("pixels_consumed", FLAT'(pidx), FLAT'(h*W));
      chk("stall_cycles", FLAT'(stallc), stall ? FLAT'(10) : '0);
    end
  endtask

  initial begin
    logic [FLAT-1:0] b0;
    rst = 1'b1; sel = 0; pv_s = 1'b0; br_s = 1'b1; pd_s = '0;
    repeat (3) @(negedge clk);
    check_reset("reset");
    rst = 1'b0;

    // Hand-computed corners of the first band of the default frame
    b0 = exp_band(0, 1, 5);
`ifdef ZERO_PAD_EN
    chk("model_b0_slot1_col4", FLAT'(b0[(1*W+4)*PW +: PW]), FLAT'(8'h04));
`else
    chk("model_b0_slot0_col4", FLAT'(b0[(0*W+4)*PW +: PW]), FLAT'(8'h04));
    chk("model_b0_slot2_col0", FLAT'(b0[(2*W+0)*PW +: PW]), FLAT'(8'h20));
`endif

    run_frame(0, 5, 1, 1'b1, 1'b0);
    run_frame(1, 5, 2, 1'b0, 1'b0);
    run_frame(2, 6, 2, 1'b0, 1'b0);

    // Reset partway into band 1, then a clean frame
    run_frame(0, 5, 1, 1'b0, 1'b1);
    @(posedge clk);
    #2 rst = 1'b1;
    pv_s = 1'b0;
    #1 check_reset("midframe_reset");
    @(negedge clk);
    rst = 1'b0;
    run_frame(0, 5, 1, 1'b0, 1'b0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
